quad_decoder: RTL

Parametrised quadrature-encoder front end: synchronises and glitch-filters the two encoder phases and the push-button, decodes phase transitions into a signed position count with step/direction pulses, and counts button presses and releases. It is the successor to the original 8-bit encoder block. It adds:

- configurable widths and filter depths
- x1/x4 resolution
- wrap or saturate arithmetic
- a synchronous clear
- illegal-transition detection

It sits between the board pins and the LED/debug outputs in `fpga_top`.

---
 rtl/quad_decoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: sync, glitch filter, decode, button counters.
// Define QDEC_ERR_EN to build illegal-transition detection (err, err_cnt).
module quad_decoder #(
   parameter int CNT_W    = 16,
   parameter int BTN_W    = 8,
   parameter int FILT     = 4,
   parameter int BTN_FILT = 16,
   parameter int X4       = 1,
   parameter int WRAP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p1,
   input  logic             p2,
   input  logic             btn,
   input  logic             clr,
   output logic [CNT_W-1:0] spin,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic [7:0]       err_cnt,
   output logic             btn_level,
   output logic [BTN_W-1:0] btndowns,
   output logic [BTN_W-1:0] btnups
);

   localparam int FW  = $clog2(FILT + 1);
   localparam int BFW = $clog2(BTN_FILT + 1);
   localparam logic [CNT_W-1:0] L_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] L_MIN = {1'b1, {(CNT_W-1){1'b0}}};

   logic [1:0]       r_p_meta;
   logic [1:0]       r_p_sync;
   logic             r_b_meta;
   logic             r_b_sync;

   logic [1:0]       r_p_cand;
   logic [FW-1:0]    r_p_cnt;
   logic [1:0]       r_f;
   logic [1:0]       r_prev;
   logic             r_b_cand;
   logic [BFW-1:0]   r_b_cnt;
   logic             r_btn_level;
   logic             r_btn_last;

   logic [CNT_W-1:0] r_spin;
   logic             r_step;
   logic             r_dir;
   logic [BTN_W-1:0] r_downs;
   logic [BTN_W-1:0] r_ups;

   logic [FW-1:0]    w_p_run;
   logic             w_p_take;
   logic [BFW-1:0]   w_b_run;
   logic             w_b_take;
   logic             w_up;
   logic             w_dn;
   logic             w_cnt_up;
   logic             w_cnt_dn;
   logic [CNT_W-1:0] w_spin_nx;

   // Synchronisers run through reset so filters can preload cleanly.
   always_ff @(posedge clk) begin
      r_p_meta <= {p1, p2};
      r_p_sync <= r_p_meta;
      r_b_meta <= btn;
      r_b_sync <= r_b_meta;
   end

   always_comb begin
      w_p_run = FW'(1);
      if (r_p_sync == r_p_cand) begin
         if (r_p_cnt == FW'(FILT))
            w_p_run = r_p_cnt;
         else
            w_p_run = r_p_cnt + FW'(1);
      end
   end

   assign w_p_take = (r_p_sync != r_f) &&
                     (w_p_run == FW'(FILT));

   always_comb begin
      w_b_run = BFW'(1);
      if (r_b_sync == r_b_cand) begin
         if (r_b_cnt == BFW'(BTN_FILT))
            w_b_run = r_b_cnt;
         else
            w_b_run = r_b_cnt + BFW'(1);
      end
   end

   assign w_b_take = (r_b_sync != r_btn_level) &&
                     (w_b_run == BFW'(BTN_FILT));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_p_cand    <= r_p_sync;
         r_p_cnt     <= '0;
         r_f         <= r_p_sync;
         r_prev      <= r_p_sync;
         r_b_cand    <= r_b_sync;
         r_b_cnt     <= '0;
         r_btn_level <= r_b_sync;
         r_btn_last  <= r_b_sync;
      end else begin
         r_p_cand   <= r_p_sync;
         r_p_cnt    <= w_p_run;
         r_prev     <= r_f;
         r_b_cand   <= r_b_sync;
         r_b_cnt    <= w_b_run;
         r_btn_last <= r_btn_level;
         if (w_p_take)
            r_f <= r_p_sync;
         if (w_b_take)
            r_btn_level <= r_b_sync;
      end
   end

   always_comb begin
      w_up = 1'b0;
      w_dn = 1'b0;
      case ({r_prev, r_f})
         4'b0001, 4'b0111,
         4'b1110, 4'b1000: w_up = 1'b1;
         4'b0010, 4'b1011,
         4'b1101, 4'b0100: w_dn = 1'b1;
         default: ;
      endcase
   end

   assign w_cnt_up = w_up &&
      ((X4 != 0) || ({r_prev, r_f} == 4'b1000));
   assign w_cnt_dn = w_dn &&
      ((X4 != 0) || ({r_prev, r_f} == 4'b0100));

   always_comb begin
      w_spin_nx = r_spin;
      if (w_cnt_up) begin
         if (!((WRAP == 0) && (r_spin == L_MAX)))
            w_spin_nx = r_spin + 1'b1;
      end else if (w_cnt_dn) begin
         if (!((WRAP == 0) && (r_spin == L_MIN)))
            w_spin_nx = r_spin - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_spin  <= '0;
         r_step  <= 1'b0;
         r_dir   <= 1'b0;
         r_downs <= '0;
         r_ups   <= '0;
      end else if (clr) begin
         r_spin  <= '0;
         r_step  <= 1'b0;
         r_downs <= '0;
         r_ups   <= '0;
      end else begin
         r_spin <= w_spin_nx;
         r_step <= w_cnt_up | w_cnt_dn;
         if (w_cnt_up | w_cnt_dn)
            r_dir <= w_cnt_up;
         if (r_btn_level && !r_btn_last)
            r_downs <= r_downs + 1'b1;
         if (!r_btn_level && r_btn_last)
            r_ups <= r_ups + 1'b1;
      end
   end

`ifdef QDEC_ERR_EN
   logic       w_ill;
   logic       r_err;
   logic [7:0] r_err_cnt;

   assign w_ill = ((r_f ^ r_prev) == 2'b11);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_ill;
         if (w_ill && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err     = r_err;
   assign err_cnt = r_err_cnt;
`else
   assign err     = 1'b0;
   assign err_cnt = 8'd0;
`endif

   assign spin      = r_spin;
   assign step      = r_step;
   assign dir       = r_dir;
   assign btn_level = r_btn_level;
   assign btndowns  = r_downs;
   assign btnups    = r_ups;

endmodule
